// File: rtl/dsp_master_arbiter.sv
// Round-robin arbiter sharing the DSP Wishbone master command port among NUM_REQ requesters.
// Serialises transactions, returns read data/done to the owner, and times out stalled cycles.
module dsp_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_address,
   input  logic [4*NUM_REQ-1:0]  req_selection,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [32*NUM_REQ-1:0] req_data_wr,
   output logic [NUM_REQ-1:0]    req_grant,
   output logic [NUM_REQ-1:0]    req_done,
   output logic                  req_err,
   output logic [31:0]           req_data_rd,
   output logic                  busy,
   output logic                  m_start,
   output logic [31:0]           m_address,
   output logic [3:0]            m_selection,
   output logic                  m_write,
   output logic [31:0]           m_data_wr,
   input  logic [31:0]           m_data_rd,
   input  logic                  m_active
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACT, S_WAIT_DONE, S_COMPLETE} state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d, win, cand;
   logic               found;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [7:0]         cnt_q, cnt_d, cnt_inc;
   logic               tmo;
   logic               err_q, err_d;
   logic [31:0]        rd_q, rd_d, addr_q, addr_d, wdat_q, wdat_d;
   logic [3:0]         sel_q, sel_d;
   logic               wr_q, wr_d;

   // First valid requester at or after ptr, wrapping around
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      cand  = ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign cnt_inc = cnt_q + 8'd1;
   assign tmo     = (cnt_inc == 8'(TIMEOUT));

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (found && !m_active) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_ACT;
         S_WAIT_ACT:  if (tmo) state_d = S_COMPLETE;
                      else if (m_active) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (!m_active || tmo) state_d = S_COMPLETE;
         S_COMPLETE:  state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      sel_d   = sel_q;
      wr_d    = wr_q;
      case (state_q)
         S_IDLE: if (found && !m_active) begin
            ptr_d   = IW'((int'(win) + 1) % NUM_REQ);
            grant_d = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (IW'(i) == win) begin
                  grant_d[i] = 1'b1;
                  addr_d     = req_address[32*i +: 32];
                  sel_d      = req_selection[4*i +: 4];
                  wr_d       = req_write[i];
                  wdat_d     = req_data_wr[32*i +: 32];
               end
            end
         end
         S_ISSUE: cnt_d = '0;
         S_WAIT_ACT, S_WAIT_DONE: begin
            cnt_d = cnt_inc;
            // A completion landing on the timeout cycle wins over the timeout
            if (state_q == S_WAIT_DONE && !m_active) begin
               err_d = 1'b0;
               rd_d  = m_data_rd;
            end else if (tmo) begin
               err_d = 1'b1;
               rd_d  = '0;
            end
         end
         S_COMPLETE: begin
            grant_d = '0;
            err_d   = 1'b0;
         end
         default: ;
      endcase
   end

   assign req_grant   = grant_q;
   assign req_done    = (state_q == S_COMPLETE) ? grant_q : '0;
   assign req_err     = (state_q == S_COMPLETE) && err_q;
   assign req_data_rd = rd_q;
   assign busy        = (state_q != S_IDLE);
   assign m_start     = (state_q == S_ISSUE);
   assign m_address   = addr_q;
   assign m_selection = sel_q;
   assign m_write     = wr_q;
   assign m_data_wr   = wdat_q;
endmodule
